// File: rtl/apple1_kbd_pkg.sv
// Shared constants, types and the character normalisation filter for the
// Apple 1 keyboard source arbiter.
package apple1_kbd_pkg;

  localparam logic [1:0] KBD_MODE_UART = 2'b00;
  localparam logic [1:0] KBD_MODE_PS2  = 2'b01;
  localparam logic [1:0] KBD_MODE_BOTH = 2'b10;

  localparam logic [6:0] ASCII_LF  = 7'h0A;
  localparam logic [6:0] ASCII_DEL = 7'h7F;
  localparam logic [6:0] APPLE1_BS = 7'h5F;

  typedef enum logic {GRANT_UART, GRANT_PS2} grant_e;
  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_e;

  typedef struct packed {
    logic       keep;
    logic [6:0] ch;
  } filt_t;

  // Apple 1 only knows upper case; LF is meaningless to the monitor and dropped.
  function automatic filt_t kbd_filter(input logic [7:0] raw);
    filt_t      f;
    logic [6:0] d;
    d      = raw[6:0];
    f.keep = 1'b1;
    f.ch   = d;
    if (d == ASCII_LF) begin
      f.keep = 1'b0;
    end else if (d == ASCII_DEL) begin
      f.ch = APPLE1_BS;
    end else if ((d >= 7'h61) && (d <= 7'h7A)) begin
      f.ch = d - 7'h20;
    end
    return f;
  endfunction

  function automatic logic uart_enabled(input logic [1:0] mode);
    return mode != KBD_MODE_PS2;
  endfunction

  function automatic logic ps2_enabled(input logic [1:0] mode);
    return mode != KBD_MODE_UART;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Small per-source character FIFO; a push on a full FIFO only lands when a
// pop frees a slot in the same cycle.
module kbd_fifo
  import apple1_kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk25,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [6:0]               push_data,
  input  logic                     pop,
  output logic [6:0]               pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [6:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    free_count = CW'(DEPTH) - count_q;
    pop_data   = mem_q[rd_ptr_q];
  end

  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & ~flush & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk25) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/kbd_source_arbiter.sv
// Merges UART and PS/2 keyboard characters into the single Apple 1 KBD
// data/strobe register, with per-source FIFOs and round-robin sharing.
module kbd_source_arbiter
  import apple1_kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_data,
  input  logic       kbd_ack,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       uart_cts,
  output logic       overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  hold_state_e   state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic [7:0]    kbd_data_q, kbd_data_d;
  logic          cts_q, cts_d;
  logic          overflow_q, overflow_d;

  logic          uart_en, ps2_en;
  filt_t         uart_f, ps2_f;
  logic          uart_push, ps2_push;
  logic          uart_pop, ps2_pop;
  logic [6:0]    uart_pop_data, ps2_pop_data;
  logic          uart_empty, ps2_empty, uart_full, ps2_full;
  logic [CW-1:0] uart_free, uart_free_next, ps2_free_unused;
  logic          uart_avail, ps2_avail;

  always_comb begin
    uart_en   = uart_enabled(mode);
    ps2_en    = ps2_enabled(mode);
    uart_f    = kbd_filter(uart_data);
    ps2_f     = kbd_filter(ps2_data);
    uart_push = uart_valid & uart_en & uart_f.keep;
    ps2_push  = ps2_valid & ps2_en & ps2_f.keep;
  end

  // A disabled source is flushed every cycle; since it also never pushes,
  // this is equivalent to a single flush on the disabling mode change.
  kbd_fifo #(.DEPTH(DEPTH)) u_uart_fifo (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .flush      (~uart_en),
    .push       (uart_push),
    .push_data  (uart_f.ch),
    .pop        (uart_pop),
    .pop_data   (uart_pop_data),
    .empty      (uart_empty),
    .full       (uart_full),
    .free_count (uart_free)
  );

  kbd_fifo #(.DEPTH(DEPTH)) u_ps2_fifo (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .flush      (~ps2_en),
    .push       (ps2_push),
    .push_data  (ps2_f.ch),
    .pop        (ps2_pop),
    .pop_data   (ps2_pop_data),
    .empty      (ps2_empty),
    .full       (ps2_full),
    .free_count (ps2_free_unused)
  );

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q      <= HOLD_EMPTY;
      last_grant_q <= GRANT_PS2;
      kbd_data_q   <= '0;
      cts_q        <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      kbd_data_q   <= kbd_data_d;
      cts_q        <= cts_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    kbd_data_d   = kbd_data_q;
    uart_pop     = 1'b0;
    ps2_pop      = 1'b0;
    uart_avail   = uart_en & ~uart_empty;
    ps2_avail    = ps2_en & ~ps2_empty;
    case (state_q)
      HOLD_EMPTY: begin
        if (uart_avail && (!ps2_avail || (last_grant_q == GRANT_PS2))) begin
          uart_pop     = 1'b1;
          kbd_data_d   = {1'b1, uart_pop_data};
          last_grant_d = GRANT_UART;
          state_d      = HOLD_FULL;
        end else if (ps2_avail) begin
          ps2_pop      = 1'b1;
          kbd_data_d   = {1'b1, ps2_pop_data};
          last_grant_d = GRANT_PS2;
          state_d      = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (kbd_ack) state_d = HOLD_EMPTY;
      end
      default: state_d = HOLD_EMPTY;
    endcase

    overflow_d = overflow_q
               | (uart_push & uart_full & ~uart_pop)
               | (ps2_push & ps2_full & ~ps2_pop);

    // CTS looks at occupancy after this cycle's push/pop, then is registered.
    uart_free_next = uart_free
                   - CW'(uart_push & (~uart_full | uart_pop))
                   + CW'(uart_pop);
    cts_d = uart_en & (uart_free_next >= CW'(2));
  end

  always_comb begin
    kbd_ready = (state_q == HOLD_FULL);
    kbd_data  = kbd_data_q;
    uart_cts  = cts_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Randomised and directed scoreboard bench for kbd_source_arbiter.
module tb_kbd_source_arbiter;

  localparam int DEPTH = 4;

  logic       clk25 = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       uart_valid, ps2_valid, kbd_ack;
  logic [7:0] uart_data, ps2_data;
  logic [7:0] kbd_data;
  logic       kbd_ready, uart_cts, overflow;

  always #20 clk25 = ~clk25;

  kbd_source_arbiter #(.DEPTH(DEPTH)) dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .mode       (mode),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .ps2_valid  (ps2_valid),
    .ps2_data   (ps2_data),
    .kbd_ack    (kbd_ack),
    .kbd_data   (kbd_data),
    .kbd_ready  (kbd_ready),
    .uart_cts   (uart_cts),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queues of normalised characters per source.
  logic [6:0] mu[$];
  logic [6:0] mp[$];
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  bit m_ready = 0, m_last_ps2 = 1, m_ovf = 0, m_cts = 0;
  bit checks_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int filt(input logic [7:0] b);
    int c;
    c = int'(b) % 128;
    if (c == 10) return -1;
    if (c == 127) return 95;
    if (c >= 97 && c <= 122) return c - 32;
    return c;
  endfunction

  task automatic cyc(input bit uv, input logic [7:0] ud, input bit pv,
                     input logic [7:0] pd, input bit ack);
    bit uen, pen, ua, pa;
    int g, us, ps, fu, fp;
    if (checks_on) begin
      chk("kbd_ready", kbd_ready, m_ready);
      chk("uart_cts", uart_cts, m_cts);
      chk("overflow", overflow, m_ovf);
    end
    uart_valid = uv; uart_data = ud;
    ps2_valid = pv;  ps2_data = pd;
    kbd_ack = ack;
    if (!rst_n) begin
      mu.delete(); mp.delete();
      m_ready = 0; m_last_ps2 = 1; m_ovf = 0; m_cts = 0;
    end else begin
      uen = (mode != 2'd1);
      pen = (mode != 2'd0);
      g = -1;
      if (m_ready) begin
        if (ack) m_ready = 0;
      end else begin
        ua = uen && (mu.size() > 0);
        pa = pen && (mp.size() > 0);
        if (ua && pa) g = m_last_ps2 ? 0 : 1;
        else if (ua)  g = 0;
        else if (pa)  g = 1;
      end
      us = mu.size();
      ps = mp.size();
      if (g == 0) begin
        exp_q.push_back({1'b1, mu.pop_front()});
        m_ready = 1; m_last_ps2 = 0;
      end else if (g == 1) begin
        exp_q.push_back({1'b1, mp.pop_front()});
        m_ready = 1; m_last_ps2 = 1;
      end
      fu = filt(ud);
      fp = filt(pd);
      if (!uen) mu.delete();
      else if (uv && fu >= 0) begin
        if (us == DEPTH && g != 0) m_ovf = 1;
        else mu.push_back(7'(fu));
      end
      if (!pen) mp.delete();
      else if (pv && fp >= 0) begin
        if (ps == DEPTH && g != 1) m_ovf = 1;
        else mp.push_back(7'(fp));
      end
      m_cts = uen && ((DEPTH - mu.size()) >= 2);
    end
    @(posedge clk25);
    #1;
    checks_on = 1;
    uart_valid = 0; ps2_valid = 0; kbd_ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(0, 8'h00, 0, 8'h00, m_ready);
  endtask

  // Monitor: each new character presented by the DUT is checked against the scoreboard.
  bit prev_ready = 0;
  always @(negedge clk25) begin
    if (kbd_ready === 1'b1 && !prev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_char: got %0h expected none", kbd_data);
      end else begin
        chk("kbd_data", kbd_data, exp_q.pop_front());
      end
      seen.push_back(kbd_data);
    end
    prev_ready = (kbd_ready === 1'b1);
  end

  initial begin
    rst_n = 0; mode = 2'b00;
    uart_valid = 0; ps2_valid = 0; kbd_ack = 0;
    uart_data = 0; ps2_data = 0;
    idle(2);
    chk("reset_kbd_data", kbd_data, 8'h00);
    rst_n = 1;

    // UART path with 2-cycle latency
    cyc(1, 8'h61, 0, 8'h00, 0);
    idle(1);
    chk("uart_latency_ready", kbd_ready, 1);
    chk("uart_latency_data", kbd_data, 8'hC1);
    cyc(0, 8'h00, 0, 8'h00, 1);
    chk("ack_clears", kbd_ready, 0);

    // Filtering
    seen.delete();
    cyc(1, 8'h0A, 0, 8'h00, 0);
    idle(3);
    chk("lf_dropped", seen.size(), 0);
    mode = 2'b01;
    cyc(0, 8'h00, 1, 8'h7F, 0);
    idle(1);
    chk("del_mapped", kbd_data, 8'hDF);
    drain(3);
    mode = 2'b00;
    cyc(0, 8'h00, 1, 8'h41, 0);
    idle(3);
    chk("ps2_ignored", kbd_ready, 0);

    // Round-robin after reset: UART wins the first tie
    rst_n = 0; idle(1); rst_n = 1;
    mode = 2'b10;
    seen.delete();
    cyc(1, 8'h41, 1, 8'h58, 0);
    cyc(1, 8'h42, 1, 8'h59, 0);
    idle(2);
    drain(12);
    chk("rr_count", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("rr_0", seen[0], 8'hC1);
      chk("rr_1", seen[1], 8'hD8);
      chk("rr_2", seen[2], 8'hC2);
      chk("rr_3", seen[3], 8'hD9);
    end

    // Overflow: holding register + 4 FIFO entries kept, sixth byte dropped
    mode = 2'b00;
    seen.delete();
    for (int i = 0; i < 6; i++) cyc(1, 8'h61 + 8'(i), 0, 8'h00, 0);
    chk("overflow_set", overflow, 1);
    chk("cts_low_full", uart_cts, 0);
    drain(16);
    chk("ovf_kept", seen.size(), 5);
    if (seen.size() == 5) chk("ovf_last", seen[4], 8'hC5);
    rst_n = 0; idle(1); rst_n = 1;

    // Mode switch flushes queued PS/2 characters
    mode = 2'b10;
    cyc(1, 8'h51, 0, 8'h00, 0);
    idle(2);
    seen.delete();
    cyc(0, 8'h00, 1, 8'h78, 0);
    cyc(0, 8'h00, 1, 8'h79, 0);
    cyc(0, 8'h00, 1, 8'h7A, 0);
    mode = 2'b00;
    idle(2);
    mode = 2'b10;
    drain(12);
    chk("no_stale", seen.size(), 0);

    // Reset mid-operation
    cyc(1, 8'h31, 1, 8'h32, 0);
    cyc(1, 8'h33, 1, 8'h34, 0);
    cyc(1, 8'h35, 1, 8'h36, 0);
    idle(1);
    rst_n = 0;
    idle(1);
    chk("rst_ready", kbd_ready, 0);
    chk("rst_data", kbd_data, 8'h00);
    chk("rst_cts", uart_cts, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1;
    idle(1);
    chk("cts_after_release", uart_cts, 1);
    seen.delete();
    drain(8);
    chk("rst_lost", seen.size(), 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ud, pd;
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
      rst_n = ($urandom_range(0, 799) != 0);
      ud = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
      pd = ($urandom_range(0, 7) == 0) ? 8'h7F : 8'($urandom);
      cyc($urandom_range(0, 3) == 0, ud, $urandom_range(0, 3) == 0, pd,
          $urandom_range(0, 2) == 0);
    end
    rst_n = 1;
    drain(40);
    @(negedge clk25);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_source_arbiter.md
# kbd_source_arbiter

Merges keyboard characters from the UART receiver and the PS/2 keyboard decoder into the single keyboard data/strobe register read by the 6502 through the PIA. Each source gets a small FIFO. A mode input selects UART-only, PS/2-only or round-robin sharing. Characters are normalised to Apple 1 form (upper case, bit 7 set), and UART flow control is driven from FIFO occupancy.

## Interface
- `DEPTH`, default 4: entries per source FIFO; power of two, at least 2.
- `clk25` in, 1: system clock, 25 MHz.
- `rst_n` in, 1: synchronous active-low reset.
- `mode` in, 2: 00 = UART only, 01 = PS/2 only, 10 = both (round-robin), 11 = treated as 10.
- `uart_valid` in, 1: one-cycle pulse; `uart_data` is valid.
- `uart_data` in, 8: received UART byte.
- `ps2_valid` in, 1: one-cycle pulse; `ps2_data` is valid.
- `ps2_data` in, 8: decoded PS/2 ASCII byte.
- `kbd_ack` in, 1: one-cycle pulse when the CPU reads the KBD data register.
- `kbd_data` out, 8: held character, bit 7 always 1.
- `kbd_ready` out, 1: a character is held (KBDCR bit 7).
- `uart_cts` out, 1: high means the host may send.
- `overflow` out, 1: sticky; a push hit a full FIFO.

## Operation
- **Input filter**, applied before push on both sources:
  - d = data & 0x7F.
  - 0x0A is dropped and never pushed.
  - 0x7F maps to 0x5F.
  - 0x61–0x7A subtract 0x20.
  - Everything else passes unchanged.
- **Push rules:**
  - A source FIFO is pushed on its valid pulse only if that source is enabled by `mode`.
  - Input from a disabled source is ignored.
  - When a mode change disables a source, that source's FIFO is flushed at the same edge.
- **Full FIFO:** a push without a simultaneous pop is dropped and sets `overflow`. A push and pop in the same cycle on a full FIFO both take effect and occupancy is unchanged.
- **Holding register:**
  - States: EMPTY (`kbd_ready`=0) and FULL (`kbd_ready`=1).
  - EMPTY → FULL when an enabled FIFO is non-empty: pop that FIFO and load `{1'b1, d[6:0]}`.
  - FULL → EMPTY on `kbd_ack`.
  - `kbd_ack` while EMPTY is ignored.
  - No load is performed in the cycle `kbd_ack` is taken, so `kbd_ready` is low for at least one cycle between characters.
- **Arbitration:**
  - Arbitration happens only in EMPTY.
  - In mode 10 with both FIFOs non-empty, grant the source not granted last.
  - The `last_grant` register updates only on a grant.
  - `last_grant` resets to PS/2, so UART wins the first tie.
  - With one FIFO non-empty, that source is granted.
- **`uart_cts`:** registered; 1 when the UART FIFO has at least 2 free entries after this cycle's push/pop; forced 0 when UART is disabled by `mode`.
- **`overflow`:** cleared only by reset.

## Timing
- **Reset values:**
  - `kbd_data` = 0x00, `kbd_ready` = 0, `uart_cts` = 0, `overflow` = 0.
  - FIFOs empty; `last_grant` = PS/2.
- **Latency:** a valid pulse sampled at edge N writes the FIFO. At edge N+1 the FIFO is popped into the holding register, and `kbd_ready` = 1 from just after N+1. That is 2 cycles from valid to ready when the holding register is EMPTY.
- **Ack:** `kbd_ack` sampled at edge M clears `kbd_ready` after M. The next queued character loads at M+1.
- `uart_cts` first rises at the edge after reset release.
- **Simultaneous events:**
  - `uart_valid` and `ps2_valid` in the same cycle push both FIFOs independently.
  - A pushed character is not visible to the arbiter until the cycle after its push; there is no bypass.
- **Reset mid-operation:** all state returns to reset values at the next edge, and in-flight characters are lost.

## Structure
- Package `apple1_kbd_pkg` holds:
  - mode encodings `KBD_MODE_UART`, `KBD_MODE_PS2`, `KBD_MODE_BOTH`;
  - character constants `ASCII_LF`, `ASCII_DEL`, `APPLE1_BS`;
  - the grant enum `{GRANT_UART, GRANT_PS2}`.
- Sub-module `kbd_fifo` (parameter `DEPTH`):
  - ports: `clk25`, `rst_n`, `flush`, `push`, `push_data`[6:0], `pop`, `pop_data`, `empty`, `full`, `free_count`;
  - instantiated once per source.
- The filter is a combinational function in the package.

## Test plan
- **UART path:** mode=00, `uart_data`=0x61 → 2 cycles later `kbd_ready`=1, `kbd_data`=0xC1. Then `kbd_ack` → `kbd_ready`=0 next cycle.
- **Filtering:**
  - UART 0x0A → never appears.
  - PS/2 0x7F in mode 01 → `kbd_data`=0xDF.
  - PS/2 in mode 00 → ignored, `kbd_ready` stays 0.
- **Round-robin:** mode=10, fill UART with 'A','B' and PS/2 with 'X','Y' before any ack → ack sequence yields 0xC1, 0xD8, 0xC2, 0xD9.
- **Overflow:** DEPTH=4, `kbd_ready` held by not acking, 6 UART bytes → holding register plus 4 FIFO entries are kept, 1 byte dropped, `overflow`=1. `uart_cts` is 0 once fewer than 2 entries are free.
- **Mode switch:** 3 bytes queued in the PS/2 FIFO, switch mode 10→00 → PS/2 FIFO flushed. Switch back to 10 → no stale characters delivered.
- **Reset:** assert `rst_n`=0 with `kbd_ready`=1 and both FIFOs non-empty → after one edge all outputs are at reset values. After release, `uart_cts`=1 one cycle later.
